// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide controller:
// FSM state encodings and operation codes.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

endpackage : muldiv_pkg

// File: rtl/addsub_w1.sv
// WIDTH+1-bit adder/subtractor. With sub=1 computes x - y as x + ~y + 1;
// cout is then the inverted borrow (1 = result non-negative).
module addsub_w1 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] x,
  input  logic [WIDTH:0] y,
  input  logic           sub,
  output logic [WIDTH:0] sum,
  output logic           cout
);

  logic [WIDTH:0] y_eff;

  // Conditionally invert y and inject the carry-in for subtraction.
  always_comb begin
    y_eff       = y ^ {(WIDTH + 1){sub}};
    {cout, sum} = {1'b0, x} + {1'b0, y_eff} + {{(WIDTH + 1){1'b0}}, sub};
  end

endmodule : addsub_w1

// File: rtl/seq_muldiv_ctrl.sv
// Sequential unsigned multiply (shift-add) / divide (restoring) unit.
// One iteration per RUN cycle, WIDTH iterations per operation; a single
// shared WIDTH+1-bit adder/subtractor serves both operations.
module seq_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_q, op_d;
  // Multiplicand for MULTU, divisor for DIVU.
  logic [WIDTH-1:0]  opnd_q, opnd_d;
  // MULTU: {hi,lo} = running product; DIVU: hi = remainder, lo = quotient.
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [WIDTH:0]    add_x, add_y, add_sum;
  logic              add_sub, add_cout;
  logic [WIDTH:0]    mult_acc;

  // Steer the shared adder: hi+multiplicand for MULTU, {rem,quot msb}-divisor for DIVU.
  always_comb begin
    if (op_q == OP_DIVU) begin
      add_x   = {hi_q, lo_q[WIDTH-1]};
      add_sub = 1'b1;
    end else begin
      add_x   = {1'b0, hi_q};
      add_sub = 1'b0;
    end
    add_y = {1'b0, opnd_q};
  end

  addsub_w1 #(.WIDTH(WIDTH)) u_addsub (
    .x    (add_x),
    .y    (add_y),
    .sub  (add_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Next-state, iteration and output logic.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mult_acc = lo_q[0] ? add_sum : {1'b0, hi_q};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          op_d    = op;
          opnd_d  = (op == OP_DIVU) ? b : a;
          hi_d    = '0;
          lo_d    = (op == OP_DIVU) ? a : b;
        end
      end
      RUN: begin
        if (op_q == OP_DIVU) begin
          if (add_cout) begin
            hi_d = add_sum[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          hi_d = mult_acc[WIDTH:1];
          lo_d = {mult_acc[0], lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULTU;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule : seq_muldiv_ctrl
